// File: rtl/vx_axi_sched_pkg.sv
// vx_axi_sched_pkg
// Shared types and width helpers for the AXI read credit scheduler.
//   sched_state_e : scheduler FSM state (ST_IDLE / ST_GRANT)
//   cnt_width()   : bits needed to hold a counter ranging 0..max
//   sel_width()   : requester index width for n requesters
package vx_axi_sched_pkg;

    localparam int unsigned PERF_CNT_BITS = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } sched_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_rr_quantum_picker.sv
// vx_rr_quantum_picker
// Combinational round-robin picker with a per-requester grant quantum.
// The last issued requester keeps priority while it stays eligible and has
// not used up its quantum; otherwise the first eligible index after it wins
// (wrapping, with the last requester itself checked last).
//   elig        : eligible requesters
//   last_idx    : last issued requester
//   qcnt        : consecutive issues already given to last_idx
//   pick_valid  : some requester was picked
//   pick_idx    : picked requester
//   pick_repeat : picked requester equals last_idx
module vx_rr_quantum_picker
    import vx_axi_sched_pkg::*;
#(
    parameter int unsigned NUM_REQS  = 2,
    parameter int unsigned QUANTUM   = 4,
    parameter int unsigned SEL_BITS  = sel_width(NUM_REQS),
    parameter int unsigned QCNT_BITS = cnt_width(QUANTUM)
) (
    input  logic [NUM_REQS-1:0]  elig,
    input  logic [SEL_BITS-1:0]  last_idx,
    input  logic [QCNT_BITS-1:0] qcnt,
    output logic                 pick_valid,
    output logic [SEL_BITS-1:0]  pick_idx,
    output logic                 pick_repeat
);

    logic [SEL_BITS-1:0] scan_idx;

    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = last_idx;
        pick_repeat = 1'b0;
        scan_idx    = '0;
        if (elig[last_idx] && (32'(qcnt) < QUANTUM)) begin
            pick_valid  = 1'b1;
            pick_repeat = 1'b1;
        end else begin
            // k == NUM_REQS lands back on last_idx: it may still win past
            // its quantum when nobody else is eligible.
            for (int unsigned k = 1; k <= NUM_REQS; k++) begin
                scan_idx = SEL_BITS'((32'(last_idx) + k) % NUM_REQS);
                if (!pick_valid && elig[scan_idx]) begin
                    pick_valid  = 1'b1;
                    pick_idx    = scan_idx;
                    pick_repeat = (k == NUM_REQS);
                end
            end
        end
    end

endmodule

// File: rtl/vx_axi_read_credit_sched.sv
// vx_axi_read_credit_sched
// Credit-based AR issue scheduler sharing one AXI read-address port among
// NUM_REQS requesters. Each requester may have up to MAX_OUTSTANDING bursts
// in flight; credits retire on R-channel last beats.
//   clk, reset     : clock, asynchronous active-low reset
//   req_valid      : per-requester AR pending
//   req_ready      : one-hot, AR of requester i accepted this cycle
//   gnt_valid/idx  : registered grant presented downstream
//   gnt_ready      : downstream arready
//   rsp_fire/last/sel : R beat handshake, rlast, requester from rid
//   idle           : no credits outstanding and no grant presented
//   err_underflow  : sticky, last beat seen with zero outstanding
// Optional: define VX_AXI_SCHED_PERF_EN to add perf_stall_credit and
// perf_stall_arb saturating per-requester stall counters.
module vx_axi_read_credit_sched
    import vx_axi_sched_pkg::*;
#(
    parameter int unsigned NUM_REQS        = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned QUANTUM         = 4,
    parameter int unsigned SEL_BITS        = sel_width(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_valid,
    output logic [NUM_REQS-1:0] req_ready,
    output logic                gnt_valid,
    output logic [SEL_BITS-1:0] gnt_idx,
    input  logic                gnt_ready,
    input  logic                rsp_fire,
    input  logic                rsp_last,
    input  logic [SEL_BITS-1:0] rsp_sel,
    output logic                idle,
    output logic                err_underflow
`ifdef VX_AXI_SCHED_PERF_EN
    ,
    output logic [PERF_CNT_BITS-1:0] perf_stall_credit [NUM_REQS],
    output logic [PERF_CNT_BITS-1:0] perf_stall_arb    [NUM_REQS]
`endif
);

    localparam int unsigned CNT_BITS  = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned QCNT_BITS = cnt_width(QUANTUM);
    localparam logic [CNT_BITS:0]    MAX_NEXT = (CNT_BITS+1)'(MAX_OUTSTANDING);
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = CNT_BITS'(MAX_OUTSTANDING);
    localparam logic [QCNT_BITS-1:0] QCNT_MAX = QCNT_BITS'(QUANTUM);

    sched_state_e         state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q [NUM_REQS];
    logic [QCNT_BITS-1:0] qcnt_q;
    logic [NUM_REQS-1:0]  issue_vec, retire_vec, under_vec, elig;
    logic                 fire, load_gnt, any_cnt;
    logic                 pick_valid, pick_repeat;
    logic [SEL_BITS-1:0]  pick_idx;

    assign gnt_valid = (state_q == ST_GRANT);
    assign fire      = gnt_valid & gnt_ready;
    assign req_ready = issue_vec;
    assign idle      = !gnt_valid && !any_cnt;

    // A same-cycle issue counts against eligibility, a same-cycle retire
    // does not (it shows up in cnt_q one cycle later).
    always_comb begin
        issue_vec  = '0;
        retire_vec = '0;
        under_vec  = '0;
        elig       = '0;
        any_cnt    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            issue_vec[i]  = fire && (gnt_idx == SEL_BITS'(i));
            retire_vec[i] = rsp_fire && rsp_last && (rsp_sel == SEL_BITS'(i));
            under_vec[i]  = retire_vec[i] && !issue_vec[i] && (cnt_q[i] == '0);
            elig[i]       = req_valid[i] &&
                            (({1'b0, cnt_q[i]} + {{CNT_BITS{1'b0}}, issue_vec[i]}) < MAX_NEXT);
            any_cnt       = any_cnt || (cnt_q[i] != '0);
        end
    end

    vx_rr_quantum_picker #(
        .NUM_REQS  (NUM_REQS),
        .QUANTUM   (QUANTUM),
        .SEL_BITS  (SEL_BITS),
        .QCNT_BITS (QCNT_BITS)
    ) u_picker (
        .elig        (elig),
        .last_idx    (gnt_idx),
        .qcnt        (qcnt_q),
        .pick_valid  (pick_valid),
        .pick_idx    (pick_idx),
        .pick_repeat (pick_repeat)
    );

    always_comb begin
        state_d  = state_q;
        load_gnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d  = ST_GRANT;
                    load_gnt = 1'b1;
                end
            end
            ST_GRANT: begin
                if (fire) begin
                    if (pick_valid) begin
                        load_gnt = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // gnt_idx doubles as the "last issued" requester: a loaded grant is
    // always issued eventually because it is held until gnt_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_idx <= '0;
            qcnt_q  <= '0;
        end else if (load_gnt) begin
            gnt_idx <= pick_idx;
            if (!pick_repeat) begin
                qcnt_q <= QCNT_BITS'(1);
            end else if (qcnt_q != QCNT_MAX) begin
                qcnt_q <= qcnt_q + QCNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                cnt_q[i] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                if (issue_vec[i] && !retire_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
                end else if (retire_vec[i] && !issue_vec[i] && !under_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_BITS'(1);
                end
            end
            if (|under_vec) begin
                err_underflow <= 1'b1;
            end
        end
    end

`ifdef VX_AXI_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                perf_stall_credit[i] <= '0;
                perf_stall_arb[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                if (req_valid[i] && (cnt_q[i] == CNT_MAX) && (perf_stall_credit[i] != '1)) begin
                    perf_stall_credit[i] <= perf_stall_credit[i] + 1'b1;
                end
                if (elig[i] && !(load_gnt && (pick_idx == SEL_BITS'(i))) &&
                    (perf_stall_arb[i] != '1)) begin
                    perf_stall_arb[i] <= perf_stall_arb[i] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_axi_read_credit_sched.sv
// Directed bench for vx_axi_read_credit_sched with NUM_REQS=2,
// MAX_OUTSTANDING=2, QUANTUM=2. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_vx_axi_read_credit_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic       gnt_valid;
    logic [0:0] gnt_idx;
    logic       gnt_ready;
    logic       rsp_fire;
    logic       rsp_last;
    logic [0:0] rsp_sel;
    logic       idle;
    logic       err_underflow;
`ifdef VX_AXI_SCHED_PERF_EN
    logic [31:0] perf_stall_credit [2];
    logic [31:0] perf_stall_arb    [2];
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    vx_axi_read_credit_sched #(
        .NUM_REQS        (2),
        .MAX_OUTSTANDING (2),
        .QUANTUM         (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .gnt_valid     (gnt_valid),
        .gnt_idx       (gnt_idx),
        .gnt_ready     (gnt_ready),
        .rsp_fire      (rsp_fire),
        .rsp_last      (rsp_last),
        .rsp_sel       (rsp_sel),
        .idle          (idle),
        .err_underflow (err_underflow)
`ifdef VX_AXI_SCHED_PERF_EN
        ,
        .perf_stall_credit (perf_stall_credit),
        .perf_stall_arb    (perf_stall_arb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic v, input logic idx, input logic [1:0] rr);
        check({tag, "_gnt_valid"}, 32'(gnt_valid), 32'(v));
        if (v) check({tag, "_gnt_idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, "_req_ready"}, 32'(req_ready), 32'(rr));
    endtask

    initial begin
        reset = 1'b0; req_valid = 2'b11; gnt_ready = 1'b1;
        rsp_fire = 1'b0; rsp_last = 1'b0; rsp_sel = 1'b0;
        step(); step();
        chk_gnt("rst", 1'b0, 1'b0, 2'b00);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_err", 32'(err_underflow), 32'd0);

        // Quantum 2, two credits each: issue order 0,0,1,1 then exhausted.
        reset = 1'b1;
        step(); chk_gnt("iss0", 1'b1, 1'b0, 2'b01);
        step(); chk_gnt("iss1", 1'b1, 1'b0, 2'b01);
        step(); chk_gnt("iss2", 1'b1, 1'b1, 2'b10);
        step(); chk_gnt("iss3", 1'b1, 1'b1, 2'b10);
        step(); chk_gnt("exh", 1'b0, 1'b0, 2'b00);
        check("exh_idle", 32'(idle), 32'd0);

        // Non-last beat must not free a credit.
        rsp_fire = 1'b1; rsp_last = 1'b0; rsp_sel = 1'b0;
        step(); rsp_fire = 1'b0;
        step(); chk_gnt("nonlast", 1'b0, 1'b0, 2'b00);
        check("nonlast_err", 32'(err_underflow), 32'd0);
`ifdef VX_AXI_SCHED_PERF_EN
        check("perf_credit0", perf_stall_credit[0], 32'd4);
`endif

        // Last beat for 0: credit at N+1, grant at N+2.
        rsp_fire = 1'b1; rsp_last = 1'b1; rsp_sel = 1'b0;
        step(); rsp_fire = 1'b0;
        chk_gnt("ret_n1", 1'b0, 1'b0, 2'b00);
        step(); chk_gnt("ret_n2", 1'b1, 1'b0, 2'b01);

        // Issue and retire to 0 in the same cycle: cnt0 stays 1.
        rsp_fire = 1'b1; rsp_last = 1'b1; rsp_sel = 1'b0;
        step(); rsp_fire = 1'b0;
        chk_gnt("both", 1'b0, 1'b0, 2'b00);
        check("both_err", 32'(err_underflow), 32'd0);
        step(); chk_gnt("both_regrant", 1'b1, 1'b0, 2'b01);
        step(); chk_gnt("both_exh", 1'b0, 1'b0, 2'b00);
        check("both_idle", 32'(idle), 32'd0);

        // Hold: grant to 1 with gnt_ready low while req_valid[1] drops.
        gnt_ready = 1'b0;
        rsp_fire = 1'b1; rsp_last = 1'b1; rsp_sel = 1'b1;
        step(); rsp_fire = 1'b0;
        step(); req_valid = 2'b01;
        chk_gnt("hold0", 1'b1, 1'b1, 2'b00);
        step(); chk_gnt("hold1", 1'b1, 1'b1, 2'b00);
        step(); chk_gnt("hold2", 1'b1, 1'b1, 2'b00);
        gnt_ready = 1'b1;
        #1 check("hold_release_rdy", 32'(req_ready), 32'h2);
        step(); chk_gnt("hold_done", 1'b0, 1'b0, 2'b00);

        // Reset asserted in the middle of a held grant.
        req_valid = 2'b11; gnt_ready = 1'b0;
        rsp_fire = 1'b1; rsp_last = 1'b1; rsp_sel = 1'b0;
        step(); rsp_fire = 1'b0;
        step(); chk_gnt("pre_mid_rst", 1'b1, 1'b0, 2'b00);
        reset = 1'b0;
        #1 check("mid_rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd1);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);

        // Underflow: last beat for 1 with zero outstanding.
        req_valid = 2'b00; reset = 1'b1;
        rsp_fire = 1'b1; rsp_last = 1'b1; rsp_sel = 1'b1;
        step(); rsp_fire = 1'b0;
        check("uf_err", 32'(err_underflow), 32'd1);
        check("uf_idle", 32'(idle), 32'd1);
        step(); check("uf_sticky", 32'(err_underflow), 32'd1);

        // cnt1 held at 0: exactly two more issues to 1 fit.
        req_valid = 2'b10; gnt_ready = 1'b1;
        step(); chk_gnt("uf_iss0", 1'b1, 1'b1, 2'b10);
        step(); chk_gnt("uf_iss1", 1'b1, 1'b1, 2'b10);
        step(); chk_gnt("uf_exh", 1'b0, 1'b0, 2'b00);
        check("uf_sticky_end", 32'(err_underflow), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
